// File: rtl/rank_order_decoder.sv
// rtl/rank_order_decoder.sv - AER rank-order event receiver rebuilding an intensity image
// Each accepted pixel index gets PIXEL_MAX_VALUE minus its arrival rank; two reset-code events open a frame.
module rank_order_decoder #(
   parameter int IMAGE_SIZE      = 256,
   parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
   parameter int PIXEL_MAX_VALUE = 255,
   parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE),
   parameter logic [IMAGE_SIZE_BITS+1:0] AER_RST_CODE = {1'b0, 1'b1, {IMAGE_SIZE_BITS{1'b1}}}
) (
   input  logic                                   CLK,
   input  logic                                   RST,
   input  logic [IMAGE_SIZE_BITS+1:0]             AERIN_ADDR,
   input  logic                                   AERIN_REQ,
   output logic                                   AERIN_ACK,
   output logic [IMAGE_SIZE*(PIXEL_BITS+1)-1:0]   IMAGE,
   output logic                                   IMAGE_VALID,
   output logic                                   IMAGE_DECODED,
   output logic [IMAGE_SIZE_BITS:0]               RANK,
   output logic                                   PROTO_ERR
);

   localparam int AW = IMAGE_SIZE_BITS + 2;
   localparam int RW = IMAGE_SIZE_BITS + 1;
   localparam int PW = PIXEL_BITS + 1;

   typedef enum logic [1:0] {IDLE, SYNC1, RECV, DONE} state_t;

   state_t                     state, state_next;
   logic [IMAGE_SIZE-1:0]      mask;
   logic                       accept, is_rstc, is_pix, dup;
   logic                       do_clear, do_write, set_err;
   logic [IMAGE_SIZE_BITS-1:0] pix_idx;
   logic [RW-1:0]              rank_inc;
   logic [PW-1:0]              value;

   // DONE never accepts, so a REQ already pending is taken once back in IDLE
   assign accept   = AERIN_REQ && !AERIN_ACK && (state != DONE);
   assign is_rstc  = (AERIN_ADDR == AER_RST_CODE);
   assign is_pix   = (AERIN_ADDR < AW'(IMAGE_SIZE));
   assign pix_idx  = AERIN_ADDR[IMAGE_SIZE_BITS-1:0];
   assign dup      = mask[pix_idx];
   assign rank_inc = RANK + RW'(1);
   assign value    = (RANK > RW'(PIXEL_MAX_VALUE)) ? '0 : PW'(PIXEL_MAX_VALUE) - PW'(RANK);

   always_comb begin
      state_next = state;
      do_clear   = 1'b0;
      do_write   = 1'b0;
      set_err    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_rstc) state_next = SYNC1;
               else         set_err    = 1'b1;
            end
         end
         SYNC1: begin
            if (accept) begin
               if (is_rstc) begin
                  state_next = RECV;
                  do_clear   = 1'b1;
               end else begin
                  state_next = IDLE;
                  set_err    = 1'b1;
               end
            end
         end
         RECV: begin
            if (accept) begin
               if (is_rstc) begin
                  state_next = SYNC1;
               end else if (is_pix && !dup) begin
                  do_write = 1'b1;
                  if (rank_inc == RW'(IMAGE_SIZE)) state_next = DONE;
               end else begin
                  set_err = 1'b1;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)              AERIN_ACK <= 1'b0;
      else if (accept)      AERIN_ACK <= 1'b1;
      else if (!AERIN_REQ)  AERIN_ACK <= 1'b0;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         IMAGE         <= '0;
         mask          <= '0;
         RANK          <= '0;
         IMAGE_VALID   <= 1'b0;
         IMAGE_DECODED <= 1'b0;
         PROTO_ERR     <= 1'b0;
      end else begin
         IMAGE_DECODED <= (state_next == DONE);
         if (state == DONE) IMAGE_VALID <= 1'b1;
         if (do_clear) begin
            IMAGE       <= '0;
            mask        <= '0;
            RANK        <= '0;
            IMAGE_VALID <= 1'b0;
            PROTO_ERR   <= 1'b0;
         end
         if (do_write) begin
            IMAGE[int'(pix_idx)*PW +: PW] <= value;
            mask[pix_idx]                 <= 1'b1;
            RANK                          <= rank_inc;
         end
         if (set_err) PROTO_ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rank_order_decoder.sv
// tb/tb_rank_order_decoder.sv - directed self-checking bench for rank_order_decoder
module tb_rank_order_decoder;

   logic         clk = 1'b0;
   logic         rst;
   logic [9:0]   addr;
   logic         req;
   logic         ack;
   logic [2303:0] image;
   logic         valid;
   logic         decoded;
   logic [8:0]   rank;
   logic         err;

   int errors = 0;
   int checks = 0;
   int dec_count = 0;

   rank_order_decoder dut (
      .CLK           (clk),
      .RST           (rst),
      .AERIN_ADDR    (addr),
      .AERIN_REQ     (req),
      .AERIN_ACK     (ack),
      .IMAGE         (image),
      .IMAGE_VALID   (valid),
      .IMAGE_DECODED (decoded),
      .RANK          (rank),
      .PROTO_ERR     (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (decoded === 1'b1) dec_count++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode 0: all zero, 1: pixel i holds i, 2: pixel i holds 255-i
   task automatic check_image(input string tag, input int mode);
      int bad;
      logic [8:0] exp;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         exp = (mode == 0) ? 9'd0 : (mode == 1) ? 9'(i) : 9'(255 - i);
         if (image[i*9 +: 9] !== exp) bad++;
      end
      check(tag, bad, 0);
   endtask

   task automatic send_event(input logic [9:0] a);
      int n;
      n = 0;
      while (ack && n < 20) begin @(posedge clk); #1; n++; end
      addr = a;
      req  = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!ack && n < 20);
      check("ack_rise", ack, 1);
      req = 1'b0;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (ack && n < 20);
      check("ack_fall", ack, 0);
   endtask

   task automatic frame_desc();
      send_event(10'h1FF);
      send_event(10'h1FF);
      for (int i = 255; i >= 0; i--) send_event(10'(i));
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; addr = '0;
      #23 rst = 1'b0;
      @(posedge clk); #1;
      check("rst_ack", ack, 0);
      check("rst_rank", rank, 0);
      check("rst_valid", valid, 0);
      check("rst_decoded", decoded, 0);
      check("rst_err", err, 0);
      check_image("rst_image", 0);

      // full frame, descending indices -> pixel i holds i
      dec_count = 0;
      frame_desc();
      check("ff_rank", rank, 256);
      check("ff_valid", valid, 1);
      check("ff_err", err, 0);
      check("ff_dec", dec_count, 1);
      check("ff_px255", image[255*9 +: 9], 255);
      check("ff_px0", image[0 +: 9], 0);
      check_image("ff_image", 1);

      // handshake timing with REQ held five cycles
      send_event(10'h1FF);
      send_event(10'h1FF);
      check("hs_valid_clr", valid, 0);
      @(posedge clk); #1;
      addr = 10'd7; req = 1'b1;
      @(posedge clk); #1;
      check("hs_ack_rise", ack, 1);
      check("hs_rank", rank, 1);
      repeat (4) begin @(posedge clk); #1; check("hs_ack_hold", ack, 1); end
      req = 1'b0;
      @(posedge clk); #1;
      check("hs_ack_fall", ack, 0);
      check("hs_rank_once", rank, 1);

      // duplicate and out-of-range
      send_event(10'd7);
      send_event(10'h300);
      check("dup_px7", image[7*9 +: 9], 255);
      check("dup_rank", rank, 1);
      check("dup_err", err, 1);

      // resync mid-frame
      send_event(10'h1FF);
      send_event(10'h1FF);
      dec_count = 0;
      for (int i = 0; i < 100; i++) send_event(10'(i));
      send_event(10'h3FF);
      check("rs_err_set", err, 1);
      check("rs_rank100", rank, 100);
      send_event(10'h1FF);
      check("rs_valid", valid, 0);
      send_event(10'h1FF);
      check("rs_err_clr", err, 0);
      check("rs_rank_clr", rank, 0);
      check_image("rs_image_clr", 0);
      check("rs_no_dec", dec_count, 0);
      for (int i = 0; i < 256; i++) send_event(10'(i));
      check("rs_dec", dec_count, 1);
      check("rs_valid_set", valid, 1);
      check_image("rs_image", 2);

      // protocol violation from IDLE after a reset
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      send_event(10'd3);
      send_event(10'h1FF);
      send_event(10'd5);
      check("pv_err", err, 1);
      check("pv_rank", rank, 0);
      check_image("pv_image", 0);
      // back in IDLE: a fresh RSTC pair must open a frame
      send_event(10'h1FF);
      send_event(10'h1FF);
      send_event(10'd9);
      check("pv_idle_rank", rank, 1);
      check("pv_idle_px9", image[9*9 +: 9], 255);
      check("pv_idle_err", err, 0);

      // async reset mid-handshake at rank 40
      for (int i = 10; i < 48; i++) send_event(10'(i));
      @(posedge clk); #1;
      addr = 10'd100; req = 1'b1;
      @(posedge clk); #1;
      check("ar_ack_pre", ack, 1);
      check("ar_rank_pre", rank, 40);
      #2 rst = 1'b1;
      #1;
      check("ar_ack", ack, 0);
      check("ar_rank", rank, 0);
      check("ar_valid", valid, 0);
      check_image("ar_image", 0);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      check("ar_reaccept", ack, 1);
      check("ar_idle_err", err, 1);
      req = 1'b0;
      @(posedge clk); #1;
      check("ar_ack_fall", ack, 0);
      dec_count = 0;
      frame_desc();
      check("ar_dec", dec_count, 1);
      check("ar_rank_full", rank, 256);
      check("ar_valid_set", valid, 1);
      check_image("ar_image_full", 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
